// File: rtl/riscv_aes_cipher_core_if.sv
// Bundle of signals between the RISC-V AES register file and the cipher core.
//   aes_start_i          : start strobe (register file -> core)
//   pt_a_i .. pt_d_i     : plaintext words, word a = state bytes 0..3
//   key_a_i .. key_d_i   : cipher key words, key_a_i = w[0]
//   busy_o               : block in flight (core -> register file)
//   valid_o              : one-cycle pulse when ct_*_o is updated
//   ct_a_o .. ct_d_o     : ciphertext words, held until the next result
// master = register-file side, slave = cipher-core side.
interface riscv_aes_cipher_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  aes_start_i;
  logic [DATA_WIDTH-1:0] pt_a_i, pt_b_i, pt_c_i, pt_d_i;
  logic [DATA_WIDTH-1:0] key_a_i, key_b_i, key_c_i, key_d_i;
  logic                  busy_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] ct_a_o, ct_b_o, ct_c_o, ct_d_o;

  modport master (
    output aes_start_i, pt_a_i, pt_b_i, pt_c_i, pt_d_i,
           key_a_i, key_b_i, key_c_i, key_d_i,
    input  busy_o, valid_o, ct_a_o, ct_b_o, ct_c_o, ct_d_o
  );

  modport slave (
    input  aes_start_i, pt_a_i, pt_b_i, pt_c_i, pt_d_i,
           key_a_i, key_b_i, key_c_i, key_d_i,
    output busy_o, valid_o, ct_a_o, ct_b_o, ct_c_o, ct_d_o
  );
endinterface

// File: rtl/riscv_aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded
// on the fly. Plaintext and key are captured on the start edge; the result is
// presented on ct_*_o with a one-cycle valid_o pulse ten cycles later.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : slave side of riscv_aes_cipher_core_if (start/pt/key in,
//         busy/valid/ct out)
//
// state | meaning
// IDLE  | waiting for aes_start_i; ct_*_o holds the last result
// ROUND | applying rounds 1..10, one per cycle
module riscv_aes_cipher_core #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 10
) (
  input logic                    clk,
  input logic                    rst,
  riscv_aes_cipher_core_if.slave bus
);
  localparam int         BW         = 4 * DATA_WIDTH;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, ROUND} state_t;

  state_t        fsm;
  logic [BW-1:0] state_reg, round_key_reg, ct_reg;
  logic [7:0]    rcon;
  logic [3:0]    round_cnt;
  logic          busy_q, valid_q;

  logic [31:0]   rot_sub, nk0, nk1, nk2, nk3;
  logic [BW-1:0] next_key, next_state;
  logic [7:0]    sb [16];
  logic [7:0]    sr [16];
  logic [7:0]    mc [16];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply; 0 maps to 0),
  // followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, b;
    sq = x;
    b  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Key schedule step: w3 rotated left one byte, substituted, rcon into byte 0.
  always_comb begin
    rot_sub = {sbox(round_key_reg[23:16]) ^ rcon, sbox(round_key_reg[15:8]),
               sbox(round_key_reg[7:0]), sbox(round_key_reg[31:24])};
    nk0 = round_key_reg[127:96] ^ rot_sub;
    nk1 = round_key_reg[95:64]  ^ nk0;
    nk2 = round_key_reg[63:32]  ^ nk1;
    nk3 = round_key_reg[31:0]   ^ nk2;
  end

  assign next_key = {nk0, nk1, nk2, nk3};

  // Byte i of a 128-bit vector lives at bits [127-8i -: 8]; column c = bytes 4c..4c+3.
  always_comb begin
    sb         = '{default: 8'h00};
    sr         = '{default: 8'h00};
    mc         = '{default: 8'h00};
    next_state = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state_reg[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      next_state[127-8*i -: 8] = ((round_cnt == LAST_ROUND) ? sr[i] : mc[i])
                                 ^ next_key[127-8*i -: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm           <= IDLE;
      state_reg     <= '0;
      round_key_reg <= '0;
      ct_reg        <= '0;
      rcon          <= 8'h01;
      round_cnt     <= 4'd0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.aes_start_i) begin
            state_reg     <= {bus.pt_a_i, bus.pt_b_i, bus.pt_c_i, bus.pt_d_i}
                           ^ {bus.key_a_i, bus.key_b_i, bus.key_c_i, bus.key_d_i};
            round_key_reg <= {bus.key_a_i, bus.key_b_i, bus.key_c_i, bus.key_d_i};
            rcon          <= 8'h01;
            round_cnt     <= 4'd1;
            busy_q        <= 1'b1;
            fsm           <= ROUND;
          end
        end
        ROUND: begin
          state_reg     <= next_state;
          round_key_reg <= next_key;
          rcon          <= xtime(rcon);
          round_cnt     <= round_cnt + 4'd1;
          if (round_cnt == LAST_ROUND) begin
            ct_reg    <= next_state;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            rcon      <= 8'h01;
            round_cnt <= 4'd0;
            fsm       <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.ct_a_o  = ct_reg[127:96];
  assign bus.ct_b_o  = ct_reg[95:64];
  assign bus.ct_c_o  = ct_reg[63:32];
  assign bus.ct_d_o  = ct_reg[31:0];
endmodule

// File: tb/tb_riscv_aes_cipher_core.sv
// Self-checking bench for riscv_aes_cipher_core: FIPS-197 vectors, timing,
// input capture, back-to-back, reset behaviour and random blocks checked
// against a byte-array AES-128 reference model.
module tb_riscv_aes_cipher_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] ref_sbox [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  riscv_aes_cipher_core_if bus ();

  riscv_aes_cipher_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box built by walking GF(2^8) with generator 3 and its inverse in step.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      ref_sbox[p] = x ^ 8'h63;
    end
    ref_sbox[0] = 8'h63;
  endtask

  // Reference AES-128: full key expansion up front, then 10 rounds on bytes.
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] a0, a1, a2, a3, t0, rc;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        t0     = tmp[0];
        tmp[0] = ref_sbox[tmp[1]] ^ rc;
        tmp[1] = ref_sbox[tmp[2]];
        tmp[2] = ref_sbox[tmp[3]];
        tmp[3] = ref_sbox[t0];
        rc     = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] ct_now();
    return {bus.ct_a_o, bus.ct_b_o, bus.ct_c_o, bus.ct_d_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic [127:0] k, input logic [127:0] p);
    {bus.key_a_i, bus.key_b_i, bus.key_c_i, bus.key_d_i} = k;
    {bus.pt_a_i, bus.pt_b_i, bus.pt_c_i, bus.pt_d_i}     = p;
    bus.aes_start_i = 1'b1;
    tick();
    bus.aes_start_i = 1'b0;
  endtask

  // Called just after the start edge; returns in the valid_o cycle.
  // poke_cycle >= 0 pulses aes_start_i while the block is in flight.
  task automatic expect_result(input string tag, input logic [127:0] exp_ct,
                               input logic [127:0] hold_ct, input int poke_cycle);
    int cycles, busy_cnt, hold_bad;
    cycles = 0; busy_cnt = 0; hold_bad = 0;
    while (bus.valid_o !== 1'b1 && cycles < 20) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (ct_now() !== hold_ct) hold_bad++;
      bus.aes_start_i = (cycles == poke_cycle);
      tick();
      cycles++;
    end
    bus.aes_start_i = 1'b0;
    check({tag, " latency"}, 128'(cycles), 128'd10);
    check({tag, " busy cycles"}, 128'(busy_cnt), 128'd10);
    check({tag, " ct held in flight"}, 128'(hold_bad), 128'd0);
    check({tag, " busy low at valid"}, 128'(bus.busy_o), 128'd0);
    check({tag, " ct"}, ct_now(), exp_ct);
  endtask

  task automatic count_valid(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.valid_o === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses, busy_seen;
    logic [127:0] last_ct, rk, rp, rexp;

    build_sbox();
    bus.aes_start_i = 1'b0;
    {bus.key_a_i, bus.key_b_i, bus.key_c_i, bus.key_d_i} = '0;
    {bus.pt_a_i, bus.pt_b_i, bus.pt_c_i, bus.pt_d_i}     = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("reset busy", 128'(bus.busy_o), 128'd0);
    check("reset valid", 128'(bus.valid_o), 128'd0);
    check("reset ct", ct_now(), 128'd0);
    rst = 1'b0;
    tick();

    // FIPS-197 C.1 with pulse width check
    start_block(C1_KEY, C1_PT);
    expect_result("c1", C1_CT, 128'd0, -1);
    tick();
    check("c1 valid width", 128'(bus.valid_o), 128'd0);
    check("c1 ct held after valid", ct_now(), C1_CT);

    // FIPS-197 appendix B
    tick();
    start_block(B_KEY, B_PT);
    expect_result("fipsb", B_CT, C1_CT, -1);
    tick();

    // Inputs change after capture; in-flight start is ignored
    start_block(C1_KEY, C1_PT);
    {bus.key_a_i, bus.key_b_i, bus.key_c_i, bus.key_d_i} = '1;
    {bus.pt_a_i, bus.pt_b_i, bus.pt_c_i, bus.pt_d_i}     = '1;
    expect_result("stable", C1_CT, B_CT, 4);
    count_valid(15, pulses);
    check("stable extra valid pulses", 128'(pulses), 128'd0);
    check("stable ct held", ct_now(), C1_CT);

    // Back-to-back: B start in the C.1 valid cycle
    start_block(C1_KEY, C1_PT);
    expect_result("b2b first", C1_CT, C1_CT, -1);
    start_block(B_KEY, B_PT);
    check("b2b valid dropped", 128'(bus.valid_o), 128'd0);
    check("b2b busy after restart", 128'(bus.busy_o), 128'd1);
    expect_result("b2b second", B_CT, C1_CT, -1);
    tick();

    // Reset in the middle of a block
    start_block(C1_KEY, C1_PT);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 128'(bus.busy_o), 128'd0);
    check("midrst valid", 128'(bus.valid_o), 128'd0);
    check("midrst ct", ct_now(), 128'd0);
    count_valid(15, pulses);
    check("midrst no valid", 128'(pulses), 128'd0);
    start_block(C1_KEY, C1_PT);
    expect_result("after midrst", C1_CT, 128'd0, -1);
    tick();

    // Reset wins over start
    busy_seen = 0;
    rst = 1'b1;
    bus.aes_start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy_o !== 1'b0) busy_seen++;
      check("rstprio valid", 128'(bus.valid_o), 128'd0);
      check("rstprio ct", ct_now(), 128'd0);
    end
    rst = 1'b0;
    bus.aes_start_i = 1'b0;
    check("rstprio busy never high", 128'(busy_seen), 128'd0);
    tick();
    check("rstprio busy after release", 128'(bus.busy_o), 128'd0);

    // Random blocks against the reference model
    last_ct = 128'd0;
    for (int n = 0; n < 12; n++) begin
      rk   = {$urandom, $urandom, $urandom, $urandom};
      rp   = {$urandom, $urandom, $urandom, $urandom};
      rexp = aes_ref(rk, rp);
      start_block(rk, rp);
      expect_result($sformatf("rand%0d", n), rexp, last_ct, -1);
      last_ct = rexp;
      if (n % 2 == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
